operand_read_sequencer: RTL and testbench

Multi-cycle operand fetch controller between the scoreboard's issue port and a register file with fewer read ports than operand slots. It accepts one instruction's set of up to five source-register reads (rs1..rs5, where rs4/rs5 are the paired `rs1+1`/`rs2+1` operands) and time-multiplexes them over `NR_RF_PORTS` synchronous read ports. It assembles the complete operand vector and presents it downstream with a valid/ready handshake. It sits in the issue stage, ahead of the functional-unit operand registers.

---
 rtl/operand_read_sequencer_pkg.sv | 10 +
 rtl/operand_read_sequencer_if.sv | 32 +++
 rtl/operand_read_sequencer_port_picker.sv | 45 ++++
 rtl/operand_read_sequencer.sv | 102 ++++++++++
 tb/tb_operand_read_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/operand_read_sequencer_pkg.sv
// Shared types for the operand read sequencer: operand slot count, FSM states
// and the per-port slot-mask type.
package opseq_pkg;
    localparam int NR_OPERANDS = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} opseq_state_e;

    // One entry per register-file port: which operand slots the port's data fills.
    typedef logic [NR_OPERANDS-1:0] opseq_map_t;
endpackage

// File: rtl/operand_read_sequencer_if.sv
// Issue-side request, register-file read and operand-output signals of the
// operand read sequencer; the sequencer uses the slave modport.
interface operand_read_sequencer_if #(
    parameter int NR_RF_PORTS   = 2,
    parameter int XLEN          = 64,
    parameter int REG_ADDR_SIZE = 5,
    parameter int TRANS_ID_BITS = 3
);
    import opseq_pkg::*;

    logic                                        req_valid_i;
    logic                                        req_ready_o;
    logic [NR_OPERANDS-1:0][REG_ADDR_SIZE-1:0]   req_rs_i;
    logic [NR_OPERANDS-1:0]                      req_rs_en_i;
    logic [TRANS_ID_BITS-1:0]                    req_trans_id_i;
    logic [NR_RF_PORTS-1:0][REG_ADDR_SIZE-1:0]   rf_raddr_o;
    logic [NR_RF_PORTS-1:0][XLEN-1:0]            rf_rdata_i;
    logic                                        op_valid_o;
    logic                                        op_ready_i;
    logic [NR_OPERANDS-1:0][XLEN-1:0]            op_data_o;
    logic [TRANS_ID_BITS-1:0]                    op_trans_id_o;

    modport slave (
        input  req_valid_i, req_rs_i, req_rs_en_i, req_trans_id_i, rf_rdata_i, op_ready_i,
        output req_ready_o, rf_raddr_o, op_valid_o, op_data_o, op_trans_id_o
    );

    modport master (
        output req_valid_i, req_rs_i, req_rs_en_i, req_trans_id_i, rf_rdata_i, op_ready_i,
        input  req_ready_o, rf_raddr_o, op_valid_o, op_data_o, op_trans_id_o
    );
endinterface

// File: rtl/operand_read_sequencer_port_picker.sv
// Combinational port assignment: lowest pending slots go to ports 0.. in order.
// Build option OPSEQ_DEDUP_EN lets pending slots with equal addresses share a port.
module opseq_port_picker
    import opseq_pkg::*;
#(
    parameter int NR_RF_PORTS   = 2,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic [NR_OPERANDS-1:0]                    i_pending,
    input  logic [NR_OPERANDS-1:0][REG_ADDR_SIZE-1:0] i_addr,
    output logic [NR_RF_PORTS-1:0][REG_ADDR_SIZE-1:0] o_port_addr,
    output opseq_map_t [NR_RF_PORTS-1:0]              o_port_map,
    output logic [NR_OPERANDS-1:0]                    o_pending_nxt
);
    always_comb begin : pick
        logic [NR_OPERANDS-1:0] v_rem;
        logic                   v_found;
        v_rem       = i_pending;
        o_port_addr = '0;
        o_port_map  = '0;
        for (int p = 0; p < NR_RF_PORTS; p++) begin
            v_found = 1'b0;
            for (int s = 0; s < NR_OPERANDS; s++) begin
                if (!v_found && v_rem[s]) begin
                    v_found          = 1'b1;
                    o_port_addr[p]   = i_addr[s];
                    o_port_map[p][s] = 1'b1;
                    v_rem[s]         = 1'b0;
                end
            end
`ifdef OPSEQ_DEDUP_EN
            // Remaining pending slots reading the same register ride on this port.
            if (v_found) begin
                for (int s = 0; s < NR_OPERANDS; s++) begin
                    if (v_rem[s] && (i_addr[s] == o_port_addr[p])) begin
                        o_port_map[p][s] = 1'b1;
                        v_rem[s]         = 1'b0;
                    end
                end
            end
`endif
        end
        o_pending_nxt = v_rem;
    end
endmodule

// File: rtl/operand_read_sequencer.sv
// Operand read sequencer: multiplexes up to five source reads over NR_RF_PORTS
// synchronous register-file ports. Optional build macro: OPSEQ_DEDUP_EN.
module operand_read_sequencer
    import opseq_pkg::*;
#(
    parameter int NR_RF_PORTS   = 2,
    parameter int XLEN          = 64,
    parameter int REG_ADDR_SIZE = 5,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    operand_read_sequencer_if.slave  bus
);
    opseq_state_e                               r_state, w_state_nxt;
    logic [NR_OPERANDS-1:0][REG_ADDR_SIZE-1:0]  r_rs;
    logic [TRANS_ID_BITS-1:0]                   r_trans_id;
    logic [NR_OPERANDS-1:0]                     r_pending, w_pending_acc, w_pending_nxt;
    opseq_map_t [NR_RF_PORTS-1:0]               r_map_p1, w_port_map;
    logic [NR_RF_PORTS-1:0][REG_ADDR_SIZE-1:0]  w_port_addr;
    logic [NR_OPERANDS-1:0][XLEN-1:0]           r_buf;
    logic                                       w_accept;

    // x0 reads are never issued; the cleared buffer already supplies their zero.
    always_comb begin
        w_pending_acc = '0;
        for (int s = 0; s < NR_OPERANDS; s++)
            w_pending_acc[s] = bus.req_rs_en_i[s] & (bus.req_rs_i[s] != '0);
    end

    assign bus.req_ready_o = (r_state == IDLE) & ~flush_i & ~rst_i;
    assign w_accept        = bus.req_valid_i & bus.req_ready_o;

    opseq_port_picker #(
        .NR_RF_PORTS   (NR_RF_PORTS),
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) u_picker (
        .i_pending     (r_pending),
        .i_addr        (r_rs),
        .o_port_addr   (w_port_addr),
        .o_port_map    (w_port_map),
        .o_pending_nxt (w_pending_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = (w_pending_acc != '0) ? ISSUE : OUT;
                ISSUE:   if (w_pending_nxt == '0) w_state_nxt = WAIT;
                WAIT:    w_state_nxt = OUT;
                OUT:     if (bus.op_ready_i) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Issue stage -> return stage: r_map_p1 steers next cycle's read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rs       <= '0;
            r_trans_id <= '0;
            r_pending  <= '0;
            r_map_p1   <= '0;
            r_buf      <= '0;
        end else if (flush_i) begin
            r_pending <= '0;
            r_map_p1  <= '0;
        end else if (w_accept) begin
            r_rs       <= bus.req_rs_i;
            r_trans_id <= bus.req_trans_id_i;
            r_pending  <= w_pending_acc;
            r_map_p1   <= '0;
            r_buf      <= '0;
        end else begin
            if (r_state == ISSUE) begin
                r_pending <= w_pending_nxt;
                r_map_p1  <= w_port_map;
            end else begin
                r_map_p1  <= '0;
            end
            for (int p = 0; p < NR_RF_PORTS; p++)
                for (int s = 0; s < NR_OPERANDS; s++)
                    if (r_map_p1[p][s]) r_buf[s] <= bus.rf_rdata_i[p];
        end
    end

    assign bus.rf_raddr_o    = (r_state == ISSUE) ? w_port_addr : '0;
    assign bus.op_valid_o    = (r_state == OUT);
    assign bus.op_data_o     = r_buf;
    assign bus.op_trans_id_o = r_trans_id;
    assign busy_o            = (r_state != IDLE);
endmodule

// File: tb/tb_operand_read_sequencer.sv
// Self-checking bench for operand_read_sequencer (two RF ports): directed and
// random request table checked against a queue-based issue model, plus flush cases.
module tb_operand_read_sequencer;
    import opseq_pkg::*;

    localparam int P  = 2;
    localparam int X  = 64;
    localparam int A  = 5;
    localparam int TW = 3;

    typedef struct {
        logic [4:0][A-1:0] rs;
        logic [4:0]        en;
        logic [TW-1:0]     tid;
        int                hold;
        int                exp_lat;   // -1: take latency from the model
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i, flush_i, busy_o;

    operand_read_sequencer_if #(.NR_RF_PORTS(P), .XLEN(X), .REG_ADDR_SIZE(A), .TRANS_ID_BITS(TW)) bus();

    operand_read_sequencer #(.NR_RF_PORTS(P), .XLEN(X), .REG_ADDR_SIZE(A), .TRANS_ID_BITS(TW)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .busy_o (busy_o),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [X-1:0] rf [32];

    // Synchronous register file: data follows the address by one cycle.
    always @(posedge clk_i)
        for (int p = 0; p < P; p++) bus.rf_rdata_i[p] <= rf[bus.rf_raddr_o[p]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per cycle, take the oldest pending slots up to P ports.
    logic [A-1:0] m_ra[$];
    int           m_k;

    function automatic void model_issue(input logic [4:0][A-1:0] rs, input logic [4:0] en);
        int           q[$];
        logic [A-1:0] a;
        m_ra.delete();
        m_k = 0;
        for (int s = 0; s < 5; s++) if (en[s] && rs[s] != 0) q.push_back(s);
        while (q.size() > 0) begin
            for (int p = 0; p < P; p++) begin
                if (q.size() > 0) begin
                    a = rs[q.pop_front()];
`ifdef OPSEQ_DEDUP_EN
                    for (int i = q.size() - 1; i >= 0; i--) if (rs[q[i]] == a) q.delete(i);
`endif
                    m_ra.push_back(a);
                end else begin
                    m_ra.push_back('0);
                end
            end
            m_k++;
        end
    endfunction

    function automatic logic [X-1:0] exp_slot(input vec_t v, input int s);
        return (v.en[s] && v.rs[s] != 0) ? rf[v.rs[s]] : '0;
    endfunction

    function automatic vec_t mk(input int r0, r1, r2, r3, r4, input logic [4:0] en,
                                input int tid, hold, lat);
        vec_t v;
        v.rs[0] = A'(r0); v.rs[1] = A'(r1); v.rs[2] = A'(r2); v.rs[3] = A'(r3); v.rs[4] = A'(r4);
        v.en = en; v.tid = TW'(tid); v.hold = hold; v.exp_lat = lat;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input string nm);
        int lat, exp_lat;
        model_issue(v.rs, v.en);
        exp_lat = (v.exp_lat >= 0) ? v.exp_lat : ((m_k == 0) ? 1 : m_k + 2);
        @(negedge clk_i);
        chk({nm, " req_ready"}, 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_rs_i       = v.rs;
        bus.req_rs_en_i    = v.en;
        bus.req_trans_id_i = v.tid;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        bus.req_rs_i    = '0;
        bus.req_rs_en_i = '0;
        lat = 1;
        while (!bus.op_valid_o && lat < 20) begin
            if (lat <= m_k)
                for (int p = 0; p < P; p++)
                    chk($sformatf("%s raddr c%0d p%0d", nm, lat, p),
                        64'(bus.rf_raddr_o[p]), 64'(m_ra[(lat-1)*P + p]));
            @(negedge clk_i);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        if (!bus.op_valid_o) return;
        for (int s = 0; s < 5; s++)
            chk($sformatf("%s data s%0d", nm, s), bus.op_data_o[s], exp_slot(v, s));
        chk({nm, " trans_id"}, 64'(bus.op_trans_id_o), 64'(v.tid));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk_i);
            chk({nm, " hold valid"}, 64'(bus.op_valid_o), 64'd1);
            chk({nm, " hold req_ready"}, 64'(bus.req_ready_o), 64'd0);
            for (int s = 0; s < 5; s++)
                chk($sformatf("%s hold data s%0d", nm, s), bus.op_data_o[s], exp_slot(v, s));
            chk({nm, " hold trans_id"}, 64'(bus.op_trans_id_o), 64'(v.tid));
        end
        bus.op_ready_i = 1'b1;
        @(negedge clk_i);
        bus.op_ready_i = 1'b0;
        chk({nm, " post valid"}, 64'(bus.op_valid_o), 64'd0);
        chk({nm, " post busy"}, 64'(busy_o), 64'd0);
    endtask

    vec_t tbl[$];

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_rs_i = '0; bus.req_rs_en_i = '0;
        bus.req_trans_id_i = '0; bus.op_ready_i = 1'b0; bus.rf_rdata_i = '0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : {$urandom, $urandom};

        tbl.push_back(mk(1, 2, 3, 4, 5, 5'b11111, 5, 0, 5));
        tbl.push_back(mk(0, 3, 7, 4, 6, 5'b00101, 2, 0, 3));
        tbl.push_back(mk(1, 2, 3, 4, 5, 5'b00000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b11111, 6, 0, 1));
        tbl.push_back(mk(3, 6, 0, 0, 0, 5'b00011, 7, 4, 3));
`ifdef OPSEQ_DEDUP_EN
        tbl.push_back(mk(9, 9, 10, 9, 0, 5'b01111, 4, 0, 3));
`else
        tbl.push_back(mk(9, 9, 10, 9, 0, 5'b01111, 4, 0, 4));
`endif
        for (int i = 0; i < 30; i++)
            tbl.push_back(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 7), 5'($urandom),
                             $urandom_range(0, 7), $urandom_range(0, 2), -1));

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst op_valid", 64'(bus.op_valid_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst raddr", 64'(bus.rf_raddr_o), 64'd0);
        chk("rst trans_id", 64'(bus.op_trans_id_o), 64'd0);
        for (int s = 0; s < 5; s++) chk($sformatf("rst data s%0d", s), bus.op_data_o[s], 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post-rst req_ready", 64'(bus.req_ready_o), 64'd1);

        for (int i = 0; i < tbl.size(); i++) do_req(tbl[i], $sformatf("vec%0d", i));

        // Flush in the second ISSUE cycle
        @(negedge clk_i);
        bus.req_valid_i = 1'b1; bus.req_rs_en_i = 5'b11111; bus.req_trans_id_i = 3'd3;
        bus.req_rs_i = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush busy before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush busy after", 64'(busy_o), 64'd0);
        chk("flush raddr", 64'(bus.rf_raddr_o), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush no valid", 64'(bus.op_valid_o), 64'd0);
            @(negedge clk_i);
        end

        // Flush beats a simultaneous request in IDLE
        flush_i = 1'b1; bus.req_valid_i = 1'b1;
        #1;
        chk("flush blocks req_ready", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0; bus.req_valid_i = 1'b0;
        chk("flush blocks accept", 64'(busy_o), 64'd0);

        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : {$urandom, $urandom};
        do_req(mk(5, 4, 3, 2, 1, 5'b11111, 6, 1, 5), "after_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
